// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle control FSM
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   localparam logic [4:0] OP_R    = 5'b00000;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b00010;
   localparam logic [4:0] ALU_OR  = 5'b00011;
   localparam logic [4:0] ALU_SLL = 5'b00100;
   localparam logic [4:0] ALU_SRA = 5'b00101;

   localparam logic [1:0] WSEL_ALU    = 2'd0;
   localparam logic [1:0] WSEL_MEM    = 2'd1;
   localparam logic [1:0] WSEL_STATUS = 2'd2;

   localparam logic [1:0] ST_NONE     = 2'd0;
   localparam logic [1:0] ST_ADD_OVF  = 2'd1;
   localparam logic [1:0] ST_ADDI_OVF = 2'd2;
   localparam logic [1:0] ST_SUB_OVF  = 2'd3;

   localparam logic [4:0] DEFAULT_STATUS_REG = 5'd30;

   // One-hot instruction class bit positions
   localparam int CLS_W    = 4;
   localparam int CLS_R    = 0;
   localparam int CLS_ADDI = 1;
   localparam int CLS_SW   = 2;
   localparam int CLS_LW   = 3;

endpackage

// File: rtl/insn_class_decode.sv
// rtl/insn_class_decode.sv - opcode/aluop to one-hot class and legal flag
module insn_class_decode
   import ctrl_pkg::*;
(
   input  logic [4:0]       opcode_i,
   input  logic [4:0]       aluop_i,
   output logic [CLS_W-1:0] cls_o,
   output logic             legal_o
);

   always_comb begin
      cls_o = '0;
      case (opcode_i)
         OP_R:    if (aluop_i <= ALU_SRA) cls_o[CLS_R] = 1'b1;
         OP_ADDI: cls_o[CLS_ADDI] = 1'b1;
         OP_SW:   cls_o[CLS_SW]   = 1'b1;
         OP_LW:   cls_o[CLS_LW]   = 1'b1;
         default: cls_o = '0;
      endcase
   end

   assign legal_o = |cls_o;

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB control FSM for the 5-bit-opcode core
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter logic [4:0] STATUS_REG = DEFAULT_STATUS_REG
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] insn_opcode,
   input  logic [4:0] insn_aluop,
   input  logic [4:0] insn_rd,
   input  logic       alu_ovf,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       pc_we,
   output logic       ir_we,
   output logic [4:0] alu_op,
   output logic       alu_b_imm,
   output logic       dmem_re,
   output logic       dmem_we,
   output logic       rf_we,
   output logic [4:0] rf_waddr,
   output logic [1:0] rf_wsel,
   output logic [1:0] status_code,
   output logic       illegal,
   output logic       busy
);

   state_e           state_q, state_d;
   logic [4:0]       opcode_q, aluop_q, rd_q;
   logic             ovf_q, ovf_d;
   logic [4:0]       dec_opcode, dec_aluop;
   logic [CLS_W-1:0] cls;
   logic             legal;
   logic             is_r, is_addi, is_sw, is_lw, is_arith;

   // DECODE must classify the live IR before its fields land in the _q registers
   assign dec_opcode = (state_q == S_DECODE) ? insn_opcode : opcode_q;
   assign dec_aluop  = (state_q == S_DECODE) ? insn_aluop  : aluop_q;

   insn_class_decode u_dec (
      .opcode_i (dec_opcode),
      .aluop_i  (dec_aluop),
      .cls_o    (cls),
      .legal_o  (legal)
   );

   assign is_r     = cls[CLS_R];
   assign is_addi  = cls[CLS_ADDI];
   assign is_sw    = cls[CLS_SW];
   assign is_lw    = cls[CLS_LW];
   assign is_arith = is_addi || (is_r && (aluop_q == ALU_ADD || aluop_q == ALU_SUB));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_FETCH;
         opcode_q <= '0;
         aluop_q  <= '0;
         rd_q     <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
         if (state_q == S_DECODE) begin
            opcode_q <= insn_opcode;
            aluop_q  <= insn_aluop;
            rd_q     <= insn_rd;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ovf_d       = ovf_q;
      pc_we       = 1'b0;
      ir_we       = 1'b0;
      alu_op      = ALU_ADD;
      alu_b_imm   = 1'b0;
      dmem_re     = 1'b0;
      dmem_we     = 1'b0;
      rf_we       = 1'b0;
      rf_waddr    = '0;
      rf_wsel     = WSEL_ALU;
      status_code = ST_NONE;
      illegal     = 1'b0;
      case (state_q)
         S_FETCH: begin
            pc_we = imem_ready;
            ir_we = imem_ready;
            if (imem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (!legal) begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_op    = is_r ? aluop_q : ALU_ADD;
            alu_b_imm = !is_r;
            ovf_d     = is_arith && alu_ovf;
            state_d   = (is_lw || is_sw) ? S_MEM : S_WB;
         end
         S_MEM: begin
            alu_op    = is_r ? aluop_q : ALU_ADD;
            alu_b_imm = !is_r;
            dmem_re   = is_lw;
            dmem_we   = is_sw;
            if (dmem_ready) state_d = is_lw ? S_WB : S_FETCH;
         end
         S_WB: begin
            rf_we   = 1'b1;
            state_d = S_FETCH;
            if (ovf_q) begin
               rf_waddr    = STATUS_REG;
               rf_wsel     = WSEL_STATUS;
               status_code = is_addi ? ST_ADDI_OVF :
                             (aluop_q == ALU_SUB) ? ST_SUB_OVF : ST_ADD_OVF;
            end else begin
               rf_waddr = rd_q;
               rf_wsel  = is_lw ? WSEL_MEM : WSEL_ALU;
            end
         end
         default: state_d = S_FETCH;
      endcase
      if (reset) begin
         pc_we   = 1'b0;
         ir_we   = 1'b0;
         dmem_re = 1'b0;
         dmem_we = 1'b0;
         rf_we   = 1'b0;
         illegal = 1'b0;
      end
   end

   assign busy = (state_q != S_FETCH);

endmodule
